// File: rtl/pds_pkg.sv
// Shared types and constants for the PDS power-grant arbiter.
package pds_pkg;

  localparam int NUM_PORTS    = 8;
  localparam int PRIO_W       = 2;
  localparam int PORT_PWR_DEF = 16;
  localparam int ALLOC_W_DEF  = 12;

  typedef enum logic [1:0] {
    IDLE,
    SHED,
    GRANT
  } pds_arb_state_t;

  typedef logic [PRIO_W-1:0] pds_prio_t;

  typedef enum logic {
    SEL_BEST,
    SEL_WORST
  } pds_sel_mode_t;

endpackage

// File: rtl/pds_prio_select.sv
// Combinational priority search over a port mask.
// Best: highest prio, lowest index wins ties. Worst: lowest prio, highest index wins ties.
module pds_prio_select #(
  parameter int N  = pds_pkg::NUM_PORTS,
  parameter int PW = pds_pkg::PRIO_W
) (
  input  logic [N-1:0]           mask,
  input  logic [N*PW-1:0]        prio,
  input  pds_pkg::pds_sel_mode_t mode,
  output logic                   valid,
  output logic [$clog2(N)-1:0]   index,
  output logic [PW-1:0]          sel_prio
);

  logic [PW-1:0] p_i;
  logic          take;

  always_comb begin
    valid    = 1'b0;
    index    = '0;
    sel_prio = '0;
    p_i      = '0;
    take     = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_i  = prio[i*PW +: PW];
      // Strict compare keeps the first hit; non-strict lets later indices take over.
      take = (mode == pds_pkg::SEL_BEST) ? (p_i > sel_prio) : (p_i <= sel_prio);
      if (mask[i] && (!valid || take)) begin
        valid    = 1'b1;
        index    = ($clog2(N))'(i);
        sel_prio = p_i;
      end
    end
  end

endmodule

// File: rtl/pds_power_arbiter.sv
// Power-grant arbiter for the 8-port PDS: keeps granted power within pwr_bdj,
// serving requests by priority with preemption and load shedding.
//
// state | meaning
// IDLE  | evaluate budget and pending requests; no grant or revoke
// SHED  | over budget: revoke the lowest-priority grant each cycle
// GRANT | grant the best pending port, or revoke a lower-priority holder
module pds_power_arbiter #(
  parameter int NUM_PORTS = pds_pkg::NUM_PORTS,
  parameter int PORT_PWR  = pds_pkg::PORT_PWR_DEF,
  parameter int ALLOC_W   = pds_pkg::ALLOC_W_DEF
) (
  input  logic                                   pclk,
  input  logic                                   prst,
  input  logic [NUM_PORTS-1:0]                   req,
  input  logic [NUM_PORTS-1:0]                   off,
  input  logic [pds_pkg::PRIO_W*NUM_PORTS-1:0]   prio,
  input  logic [7:0]                             pwr_bdj,
  input  logic                                   ports_off,
  output logic [NUM_PORTS-1:0]                   gnt,
  output logic [ALLOC_W-1:0]                     alloc_pwr,
  output logic                                   busy
);

  import pds_pkg::*;

  localparam int               IDX_W  = $clog2(NUM_PORTS);
  localparam logic [ALLOC_W:0] STEP_X = (ALLOC_W+1)'(PORT_PWR);
  localparam logic [ALLOC_W-1:0] STEP = ALLOC_W'(PORT_PWR);

  pds_arb_state_t       state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [ALLOC_W-1:0]   alloc_q, alloc_d;

  logic [NUM_PORTS-1:0] released;
  logic [NUM_PORTS-1:0] gnt_eff;
  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] pending_nxt;
  logic [NUM_PORTS-1:0] cand_onehot;
  logic [ALLOC_W-1:0]   alloc_eff;
  logic [ALLOC_W:0]     alloc_x;
  logic [ALLOC_W:0]     bdj_x;

  logic                 cand_vld;
  logic                 victim_vld;
  logic [IDX_W-1:0]     cand_idx;
  logic [IDX_W-1:0]     victim_idx;
  pds_prio_t            cand_prio;
  pds_prio_t            victim_prio;

  logic                 fits;
  logic                 fits_two;
  logic                 over;
  logic                 preempt_ok;
  logic                 shed_done;
  logic                 higher_waiting;
  logic                 more_after_grant;

  // Drops and force-offs return their power before any arbitration this edge.
  always_comb begin
    released  = gnt_q & (~req | off);
    gnt_eff   = gnt_q & ~released;
    alloc_eff = alloc_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (released[i]) begin
        alloc_eff = alloc_eff - STEP;
      end
    end
    pending = req & ~off & ~gnt_eff;
  end

  pds_prio_select #(
    .N  (NUM_PORTS),
    .PW (PRIO_W)
  ) u_cand (
    .mask     (pending),
    .prio     (prio),
    .mode     (SEL_BEST),
    .valid    (cand_vld),
    .index    (cand_idx),
    .sel_prio (cand_prio)
  );

  pds_prio_select #(
    .N  (NUM_PORTS),
    .PW (PRIO_W)
  ) u_victim (
    .mask     (gnt_eff),
    .prio     (prio),
    .mode     (SEL_WORST),
    .valid    (victim_vld),
    .index    (victim_idx),
    .sel_prio (victim_prio)
  );

  always_comb begin
    alloc_x    = {1'b0, alloc_eff};
    bdj_x      = (ALLOC_W+1)'(pwr_bdj);
    fits       = (alloc_x + STEP_X) <= bdj_x;
    fits_two   = (alloc_x + (STEP_X << 1)) <= bdj_x;
    over       = alloc_x > bdj_x;
    shed_done  = alloc_x <= (bdj_x + STEP_X);
    preempt_ok = cand_vld && victim_vld && (victim_prio < cand_prio);

    // After granting cand, the weakest holder is still victim whenever a
    // preempt could follow, so only the remaining pending set needs scanning.
    cand_onehot    = NUM_PORTS'(1) << cand_idx;
    pending_nxt    = pending & ~cand_onehot;
    higher_waiting = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pending_nxt[i] && (prio[i*PRIO_W +: PRIO_W] > victim_prio)) begin
        higher_waiting = 1'b1;
      end
    end
    more_after_grant = ((|pending_nxt) && fits_two) || (preempt_ok && higher_waiting);
  end

  always_comb begin
    gnt_d   = gnt_eff;
    alloc_d = alloc_eff;
    state_d = state_q;
    if (ports_off) begin
      gnt_d   = '0;
      alloc_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (over) begin
            state_d = SHED;
          end else if (cand_vld && (fits || preempt_ok)) begin
            state_d = GRANT;
          end
        end
        SHED: begin
          if (over && victim_vld) begin
            gnt_d[victim_idx] = 1'b0;
            alloc_d           = alloc_eff - STEP;
            state_d           = shed_done ? IDLE : SHED;
          end else begin
            state_d = IDLE;
          end
        end
        GRANT: begin
          if (over) begin
            state_d = SHED;
          end else if (cand_vld && fits) begin
            gnt_d[cand_idx] = 1'b1;
            alloc_d         = alloc_eff + STEP;
            state_d         = more_after_grant ? GRANT : IDLE;
          end else if (preempt_ok) begin
            // Freed power always fits cand next cycle, so stay in GRANT.
            gnt_d[victim_idx] = 1'b0;
            alloc_d           = alloc_eff - STEP;
            state_d           = GRANT;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      alloc_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      alloc_q <= alloc_d;
    end
  end

  assign gnt       = gnt_q;
  assign alloc_pwr = alloc_q;
  assign busy      = (state_q != IDLE);

endmodule
